// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared widths, address split and pseudo-LRU helpers for icache1.
// Revision    : 1.0
// ============================================================================
package icache_pkg;

  localparam int ADDR_WIDTH      = 32;
  localparam int CACHE_SET       = 64;
  localparam int CACHELINE_WIDTH = 128;
  localparam int WAYS            = 4;
  localparam int OFF             = $clog2(CACHELINE_WIDTH / 8);
  localparam int IDX             = $clog2(CACHE_SET);
  localparam int CACHE_TAG_WIDTH = ADDR_WIDTH - IDX - OFF;

  typedef logic [ADDR_WIDTH-1:0]      addr_t;
  typedef logic [IDX-1:0]             idx_t;
  typedef logic [CACHE_TAG_WIDTH-1:0] tag_t;
  typedef logic [CACHELINE_WIDTH-1:0] line_t;
  typedef logic [1:0]                 way_t;
  typedef logic [2:0]                 plru_t;

  function automatic idx_t get_idx(input addr_t a);
    return a[OFF+IDX-1:OFF];
  endfunction

  function automatic tag_t get_tag(input addr_t a);
    return a[ADDR_WIDTH-1:OFF+IDX];
  endfunction

  // b0 selects the pair, b1/b2 select the way inside pair {0,1}/{2,3}
  function automatic way_t plru_victim(input plru_t b);
    if (b[0]) return b[2] ? 2'd3 : 2'd2;
    return b[1] ? 2'd1 : 2'd0;
  endfunction

  function automatic plru_t plru_touch(input plru_t b, input way_t w);
    plru_t r;
    r = b;
    case (w)
      2'd0:    begin r[0] = 1'b1; r[1] = 1'b1; end
      2'd1:    begin r[0] = 1'b1; r[1] = 1'b0; end
      2'd2:    begin r[0] = 1'b0; r[2] = 1'b1; end
      default: begin r[0] = 1'b0; r[2] = 1'b0; end
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache1_if.sv
`default_nettype none
// ============================================================================
// Module      : icache1_if
// Description : Fetch request, stage-2 feedback and stage-2 output bundle.
// Revision    : 1.0
// ============================================================================
interface icache1_if;
  import icache_pkg::*;

  logic  Icachestop;
  logic  Icacheflush;
  addr_t pc;
  logic  pc_valid;
  logic  hit_valid;
  idx_t  hit_set;
  way_t  hit_way;
  logic  refill_valid;
  idx_t  refill_set;
  tag_t  refill_tag;
  line_t refill_data;

  logic            tos2_valid;
  addr_t           tos2_pc;
  line_t           tos2_data [0:WAYS-1];
  tag_t            tos2_tag  [0:WAYS-1];
  logic [WAYS-1:0] tos2_way_valid;

  modport master (
    output Icachestop, Icacheflush, pc, pc_valid,
    output hit_valid, hit_set, hit_way,
    output refill_valid, refill_set, refill_tag, refill_data,
    input  tos2_valid, tos2_pc, tos2_data, tos2_tag, tos2_way_valid
  );

  modport slave (
    input  Icachestop, Icacheflush, pc, pc_valid,
    input  hit_valid, hit_set, hit_way,
    input  refill_valid, refill_set, refill_tag, refill_data,
    output tos2_valid, tos2_pc, tos2_data, tos2_tag, tos2_way_valid
  );

endinterface
`default_nettype wire

// File: rtl/icache_plru.sv
`default_nettype none
// ============================================================================
// Module      : icache_plru
// Description : Per-set 3-bit tree pseudo-LRU state with victim lookup.
// Revision    : 1.0
// ============================================================================
module icache_plru
  import icache_pkg::*;
(
  input  wire logic clk,
  input  wire logic rstn,
  input  wire logic i_hit_valid,
  input  wire idx_t i_hit_set,
  input  wire way_t i_hit_way,
  input  wire logic i_refill_valid,
  input  wire idx_t i_refill_set,
  input  wire way_t i_refill_way,
  output      way_t o_victim_way
);

  plru_t r_bits [0:CACHE_SET-1];

  assign o_victim_way = plru_victim(r_bits[i_refill_set]);

  // A refill touch takes precedence over a hit touch on the same set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < CACHE_SET; s++) r_bits[s] <= '0;
    end else begin
      for (int s = 0; s < CACHE_SET; s++) begin
        if (i_refill_valid && (i_refill_set == idx_t'(s)))
          r_bits[s] <= plru_touch(r_bits[s], i_refill_way);
        else if (i_hit_valid && (i_hit_set == idx_t'(s)))
          r_bits[s] <= plru_touch(r_bits[s], i_hit_way);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/icache1.sv
`default_nettype none
// ============================================================================
// Module      : icache1
// Description : I-cache stage 1: 4-way tag/data/valid arrays, PLRU, stage-2 register.
// Revision    : 1.0
// ============================================================================
module icache1
  import icache_pkg::*;
(
  input wire logic  clk,
  input wire logic  rstn,
  icache1_if.slave  bus
);

  tag_t            r_tag   [0:CACHE_SET-1][0:WAYS-1];
  line_t           r_data  [0:CACHE_SET-1][0:WAYS-1];
  logic [WAYS-1:0] r_valid [0:CACHE_SET-1];

  logic            r_tos2_valid;
  addr_t           r_tos2_pc;
  line_t           r_tos2_data [0:WAYS-1];
  tag_t            r_tos2_tag  [0:WAYS-1];
  logic [WAYS-1:0] r_tos2_way_valid;

  way_t            w_plru_way;
  way_t            w_victim;
  logic [WAYS-1:0] w_set_valid;
  addr_t           w_rd_pc;
  idx_t            w_rd_idx;
  logic            w_bypass;

  icache_plru u_plru (
    .clk            (clk),
    .rstn           (rstn),
    .i_hit_valid    (bus.hit_valid),
    .i_hit_set      (bus.hit_set),
    .i_hit_way      (bus.hit_way),
    .i_refill_valid (bus.refill_valid),
    .i_refill_set   (bus.refill_set),
    .i_refill_way   (w_victim),
    .o_victim_way   (w_plru_way)
  );

  // Lowest-numbered invalid way wins; PLRU only decides in a full set
  always_comb begin
    w_set_valid = r_valid[bus.refill_set];
    w_victim    = w_plru_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_set_valid[w]) w_victim = way_t'(w);
    end
  end

  assign w_rd_pc  = (bus.Icacheflush || bus.Icachestop) ? r_tos2_pc : bus.pc;
  assign w_rd_idx = get_idx(w_rd_pc);
  assign w_bypass = bus.refill_valid && (bus.refill_set == w_rd_idx);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < CACHE_SET; s++) r_valid[s] <= '0;
    end else if (bus.refill_valid) begin
      r_valid[bus.refill_set][w_victim] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.refill_valid) begin
      r_tag[bus.refill_set][w_victim]  <= bus.refill_tag;
      r_data[bus.refill_set][w_victim] <= bus.refill_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tos2_valid     <= 1'b0;
      r_tos2_pc        <= '0;
      r_tos2_way_valid <= '0;
      for (int w = 0; w < WAYS; w++) begin
        r_tos2_data[w] <= '0;
        r_tos2_tag[w]  <= '0;
      end
    end else begin
      if (bus.Icacheflush) begin
        r_tos2_valid <= 1'b0;
      end else if (!bus.Icachestop) begin
        r_tos2_valid <= bus.pc_valid;
        r_tos2_pc    <= bus.pc;
      end
      // Same-cycle refill into the set being read is forwarded to its victim way
      for (int w = 0; w < WAYS; w++) begin
        if (w_bypass && (w_victim == way_t'(w))) begin
          r_tos2_data[w]      <= bus.refill_data;
          r_tos2_tag[w]       <= bus.refill_tag;
          r_tos2_way_valid[w] <= 1'b1;
        end else begin
          r_tos2_data[w]      <= r_data[w_rd_idx][w];
          r_tos2_tag[w]       <= r_tag[w_rd_idx][w];
          r_tos2_way_valid[w] <= r_valid[w_rd_idx][w];
        end
      end
    end
  end

  assign bus.tos2_valid     = r_tos2_valid;
  assign bus.tos2_pc        = r_tos2_pc;
  assign bus.tos2_way_valid = r_tos2_way_valid;

  for (genvar g = 0; g < WAYS; g++) begin : g_way_out
    assign bus.tos2_data[g] = r_tos2_data[g];
    assign bus.tos2_tag[g]  = r_tos2_tag[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_icache1.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache1
// Description : Directed scoreboard bench for icache1 stage-1 behaviour.
// Revision    : 1.0
// ============================================================================
module tb_icache1;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  icache1_if bus ();

  icache1 dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  typedef struct {
    int         cyc;
    logic       valid;
    bit         chk_pc;
    addr_t      pc;
    bit         chk_wv;
    logic [3:0] wv;
    int         way;
    tag_t       tag;
    line_t      data;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];
  int    cyc      = 0;
  int    n_checks = 0;
  int    n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic line_t mkdata(input int t);
    return {32'hC0DE0000 + 32'(t), 32'(t), 64'h0123_4567_89AB_CDEF};
  endfunction

  task automatic check(input string nm, input string field,
                       input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h", nm, field, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input logic v, input bit cp, input addr_t p,
                            input bit cw, input logic [3:0] wv, input int way,
                            input tag_t t, input line_t d);
    exp_t e;
    e.cyc = cyc + 1; e.valid = v; e.chk_pc = cp; e.pc = p;
    e.chk_wv = cw; e.wv = wv; e.way = way; e.tag = t; e.data = d;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares every expectation scheduled for the current cycle
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.cyc != cyc) check(nm, "cycle", 128'(cyc), 128'(e.cyc));
      check(nm, "tos2_valid", 128'(bus.tos2_valid), 128'(e.valid));
      if (e.chk_pc) check(nm, "tos2_pc", 128'(bus.tos2_pc), 128'(e.pc));
      if (e.chk_wv) check(nm, "tos2_way_valid", 128'(bus.tos2_way_valid), 128'(e.wv));
      if (e.way >= 0) begin
        check(nm, "tos2_tag", 128'(bus.tos2_tag[e.way]), 128'(e.tag));
        check(nm, "tos2_data", bus.tos2_data[e.way], e.data);
      end
    end
  end

  task automatic idle();
    bus.Icachestop   = 1'b0;
    bus.Icacheflush  = 1'b0;
    bus.pc           = '0;
    bus.pc_valid     = 1'b0;
    bus.hit_valid    = 1'b0;
    bus.hit_set      = '0;
    bus.hit_way      = '0;
    bus.refill_valid = 1'b0;
    bus.refill_set   = '0;
    bus.refill_tag   = '0;
    bus.refill_data  = '0;
  endtask

  task automatic refill(input int set, input int t);
    bus.refill_valid = 1'b1;
    bus.refill_set   = idx_t'(set);
    bus.refill_tag   = tag_t'(t);
    bus.refill_data  = mkdata(t);
  endtask

  localparam line_t D2 = 128'hDEADBEEF_CAFECAFE_12345678_ABCDEF01;

  initial begin
    rstn = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    expect_out("reset", 1'b0, 1, '0, 1, 4'b0000, 0, '0, '0);
    @(negedge clk);
    rstn = 1'b1;

    // Cold miss: request registered, no valid ways
    bus.pc = 32'h1000_0000; bus.pc_valid = 1'b1;
    expect_out("cold_req", 1'b1, 1, 32'h1000_0000, 1, 4'b0000, -1, '0, '0);
    @(negedge clk); idle();

    bus.refill_valid = 1'b1; bus.refill_set = '0;
    bus.refill_tag = 22'h40000; bus.refill_data = D2;
    @(negedge clk); idle();
    bus.pc = 32'h1000_0000; bus.pc_valid = 1'b1;
    expect_out("refill_way0", 1'b1, 1, 32'h1000_0000, 1, 4'b0001, 0, 22'h40000, D2);
    @(negedge clk); idle();

    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Fill set 0 in way order, touch way 0, then the PLRU victim is way 2
    for (int t = 1; t <= 4; t++) begin
      refill(0, t);
      @(negedge clk);
    end
    idle();
    bus.pc_valid = 1'b1;
    expect_out("fill_way3", 1'b1, 1, '0, 1, 4'b1111, 3, tag_t'(4), mkdata(4));
    expect_out("fill_way1", 1'b1, 0, '0, 0, 4'b0000, 1, tag_t'(2), mkdata(2));
    @(negedge clk); idle();
    bus.hit_valid = 1'b1; bus.hit_set = '0; bus.hit_way = 2'd0;
    @(negedge clk); idle();
    refill(0, 5);
    @(negedge clk); idle();
    bus.pc_valid = 1'b1;
    expect_out("plru_way2", 1'b1, 1, '0, 1, 4'b1111, 2, tag_t'(5), mkdata(5));
    expect_out("keep_way0", 1'b1, 0, '0, 0, 4'b0000, 0, tag_t'(1), mkdata(1));
    @(negedge clk); idle();

    // Same-cycle refill into the read set shows up immediately in way 1
    bus.pc_valid = 1'b1;
    refill(0, 6);
    expect_out("bypass_way1", 1'b1, 1, '0, 1, 4'b1111, 1, tag_t'(6), mkdata(6));
    expect_out("bypass_way2", 1'b1, 0, '0, 0, 4'b0000, 2, tag_t'(5), mkdata(5));
    @(negedge clk); idle();

    // Stall: request to set 1 held while pc wanders; refill lands mid-stall
    bus.pc = 32'h0000_0010; bus.pc_valid = 1'b1;
    expect_out("stall_req", 1'b1, 1, 32'h10, 1, 4'b0000, -1, '0, '0);
    @(negedge clk); idle();
    bus.Icachestop = 1'b1; bus.pc = 32'h20;
    expect_out("stall_a", 1'b1, 1, 32'h10, 1, 4'b0000, -1, '0, '0);
    @(negedge clk); idle();
    bus.Icachestop = 1'b1; bus.pc = 32'h30; bus.pc_valid = 1'b1;
    refill(1, 32'h77);
    expect_out("stall_b", 1'b1, 1, 32'h10, 1, 4'b0001, 0, tag_t'(32'h77), mkdata(32'h77));
    @(negedge clk); idle();
    bus.Icachestop = 1'b1; bus.pc = 32'h40;
    expect_out("stall_c", 1'b1, 1, 32'h10, 1, 4'b0001, 0, tag_t'(32'h77), mkdata(32'h77));
    @(negedge clk); idle();

    // Flush beats stop and pc_valid; arrays survive
    bus.Icacheflush = 1'b1; bus.Icachestop = 1'b1; bus.pc_valid = 1'b1;
    expect_out("flush", 1'b0, 0, '0, 0, 4'b0000, -1, '0, '0);
    @(negedge clk); idle();
    bus.pc_valid = 1'b1;
    expect_out("post_flush_w1", 1'b1, 1, '0, 1, 4'b1111, 1, tag_t'(6), mkdata(6));
    expect_out("post_flush_w2", 1'b1, 0, '0, 0, 4'b0000, 2, tag_t'(5), mkdata(5));
    expect_out("post_flush_w3", 1'b1, 0, '0, 0, 4'b0000, 3, tag_t'(4), mkdata(4));
    @(negedge clk); idle();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
